// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encoding, requester
// indices and one-hot grant codes for the FFT/FIR/IIR accelerators.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t IDX_FFT = 2'd0;
  localparam req_idx_t IDX_FIR = 2'd1;
  localparam req_idx_t IDX_IIR = 2'd2;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_FFT  = 3'b001;
  localparam logic [2:0] GNT_FIR  = 3'b010;
  localparam logic [2:0] GNT_IIR  = 3'b100;

  function automatic req_idx_t onehot_to_idx(input logic [2:0] oh);
    req_idx_t idx;
    idx = IDX_FFT;
    if (oh[2])      idx = IDX_IIR;
    else if (oh[1]) idx = IDX_FIR;
    return idx;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_picker_3.sv
// Combinational 3-way round-robin selector: searches the request vector
// starting just after the last-served requester and returns a one-hot grant.
module rr_picker_3
  import ram_port_arbiter_pkg::*;
(
  input  logic [2:0] req_i,
  input  req_idx_t   rr_ptr_i,
  output logic [2:0] grant_o
);

  // NOTE: grant_o gets a default before the case so no path leaves it
  // unassigned; without it this block would infer a latch.
  always_comb begin
    grant_o = GNT_NONE;
    case (rr_ptr_i)
      IDX_FFT: begin
        if      (req_i[1]) grant_o = GNT_FIR;
        else if (req_i[2]) grant_o = GNT_IIR;
        else if (req_i[0]) grant_o = GNT_FFT;
      end
      IDX_FIR: begin
        if      (req_i[2]) grant_o = GNT_IIR;
        else if (req_i[0]) grant_o = GNT_FFT;
        else if (req_i[1]) grant_o = GNT_FIR;
      end
      default: begin
        if      (req_i[0]) grant_o = GNT_FFT;
        else if (req_i[1]) grant_o = GNT_FIR;
        else if (req_i[2]) grant_o = GNT_IIR;
      end
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner of the single RAM port shared by the FFT, FIR and IIR
// accelerators; runs bounded read/write bursts and drives the FIFO strobes.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 5,
  parameter int STALL_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             fft_rd_req,
  input  logic             fir_rd_req,
  input  logic             iir_rd_req,
  input  logic             fft_wr_req,
  input  logic             fir_wr_req,
  input  logic             iir_wr_req,
  input  logic             to_fft_full,
  input  logic             to_fir_full,
  input  logic             to_iir_full,
  input  logic             from_fft_empty,
  input  logic             from_fir_empty,
  input  logic             from_iir_empty,
  output logic [2:0]       grant,
  output logic             grant_wr,
  output logic             ram_read_enable,
  output logic             ram_write_enable,
  output logic             fft_put_req,
  output logic             fir_put_req,
  output logic             iir_put_req,
  output logic             fft_get_req,
  output logic             fir_get_req,
  output logic             iir_get_req,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             burst_done
);

  localparam int STALL_W = $clog2(STALL_MAX + 1);

  state_e             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic               grant_wr_q, grant_wr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  req_idx_t           rr_ptr_q, rr_ptr_d;

  logic [2:0]         rd_req_v, wr_req_v, full_v, empty_v, any_req_v, pick;
  logic               any_req, xfer_active, dir_req, rd_beat, wr_beat, beat;
  logic               last_beat, stall_timeout;
  logic [STALL_W-1:0] stall_next;

  assign rd_req_v  = {iir_rd_req, fir_rd_req, fft_rd_req};
  assign wr_req_v  = {iir_wr_req, fir_wr_req, fft_wr_req};
  assign full_v    = {to_iir_full, to_fir_full, to_fft_full};
  assign empty_v   = {from_iir_empty, from_fir_empty, from_fft_empty};
  assign any_req_v = rd_req_v | wr_req_v;
  assign any_req   = |any_req_v;

  rr_picker_3 u_picker (
    .req_i    (any_req_v),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick)
  );

  // Beats are decided from the registered grant and today's FIFO flags, so the
  // RAM strobe and the FIFO strobe rise in the same cycle. Chipselect gates
  // them immediately rather than waiting for the FSM to reach IDLE.
  assign xfer_active = (state_q == ST_XFER) && chipselect;
  assign dir_req     = grant_wr_q ? |(grant_q & wr_req_v) : |(grant_q & rd_req_v);
  assign rd_beat     = xfer_active && !grant_wr_q && |(grant_q & rd_req_v & ~full_v);
  assign wr_beat     = xfer_active &&  grant_wr_q && |(grant_q & wr_req_v & ~empty_v);
  assign beat        = rd_beat || wr_beat;

  assign stall_next    = (stall_cnt_q == STALL_W'(STALL_MAX)) ? stall_cnt_q
                                                              : stall_cnt_q + 1'b1;
  assign last_beat     = beat && (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign stall_timeout = !beat && (stall_next == STALL_W'(STALL_MAX));

  // NOTE: every register here uses non-blocking assignment so all flops
  // sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      grant_wr_q  <= 1'b0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      rr_ptr_q    <= IDX_FFT;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_wr_q  <= grant_wr_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_wr_d  = grant_wr_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    rr_ptr_d    = rr_ptr_q;

    if (!chipselect) begin
      state_d     = ST_IDLE;
      grant_d     = GNT_NONE;
      grant_wr_d  = 1'b0;
      beat_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) state_d = ST_ARB;
        end
        ST_ARB: begin
          if (pick != GNT_NONE) begin
            state_d     = ST_XFER;
            grant_d     = pick;
            // Write wins when the chosen requester asks for both directions.
            grant_wr_d  = |(pick & wr_req_v);
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_XFER: begin
          if (beat) begin
            beat_cnt_d  = beat_cnt_q + 1'b1;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_next;
          end
          if (last_beat || !dir_req || stall_timeout) state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          rr_ptr_d    = onehot_to_idx(grant_q);
          grant_d     = GNT_NONE;
          grant_wr_d  = 1'b0;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
          state_d     = any_req ? ST_ARB : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant            = chipselect ? grant_q : GNT_NONE;
    grant_wr         = chipselect && grant_wr_q;
    beat_cnt         = beat_cnt_q;
    burst_done       = chipselect && (state_q == ST_RELEASE);
    ram_read_enable  = rd_beat;
    ram_write_enable = wr_beat;
    fft_put_req      = rd_beat && grant_q[0];
    fir_put_req      = rd_beat && grant_q[1];
    iir_put_req      = rd_beat && grant_q[2];
    fft_get_req      = wr_beat && grant_q[0];
    fir_get_req      = wr_beat && grant_q[1];
    iir_get_req      = wr_beat && grant_q[2];
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: single burst, stall timeout, write
// priority, round-robin rotation, chipselect abort and async reset.
module tb_ram_port_arbiter;

  logic       clk;
  logic       reset;
  logic       chipselect;
  logic       fft_rd_req, fir_rd_req, iir_rd_req;
  logic       fft_wr_req, fir_wr_req, iir_wr_req;
  logic       to_fft_full, to_fir_full, to_iir_full;
  logic       from_fft_empty, from_fir_empty, from_iir_empty;
  logic [2:0] grant;
  logic       grant_wr;
  logic       ram_read_enable, ram_write_enable;
  logic       fft_put_req, fir_put_req, iir_put_req;
  logic       fft_get_req, fir_get_req, iir_get_req;
  logic [4:0] beat_cnt;
  logic       burst_done;
  logic [2:0] put_v, get_v;

  int n_checks = 0;
  int n_errors = 0;

  assign put_v = {iir_put_req, fir_put_req, fft_put_req};
  assign get_v = {iir_get_req, fir_get_req, fft_get_req};

  ram_port_arbiter #(.BURST_LEN(16), .CNT_W(5), .STALL_MAX(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .chipselect       (chipselect),
    .fft_rd_req       (fft_rd_req),
    .fir_rd_req       (fir_rd_req),
    .iir_rd_req       (iir_rd_req),
    .fft_wr_req       (fft_wr_req),
    .fir_wr_req       (fir_wr_req),
    .iir_wr_req       (iir_wr_req),
    .to_fft_full      (to_fft_full),
    .to_fir_full      (to_fir_full),
    .to_iir_full      (to_iir_full),
    .from_fft_empty   (from_fft_empty),
    .from_fir_empty   (from_fir_empty),
    .from_iir_empty   (from_iir_empty),
    .grant            (grant),
    .grant_wr         (grant_wr),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .fft_put_req      (fft_put_req),
    .fir_put_req      (fir_put_req),
    .iir_put_req      (iir_put_req),
    .fft_get_req      (fft_get_req),
    .fir_get_req      (fir_get_req),
    .iir_get_req      (iir_get_req),
    .beat_cnt         (beat_cnt),
    .burst_done       (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Called at the sample point of an ARB cycle with every rd_req held and no
  // FIFO full: checks one full 16-beat read burst and its RELEASE cycle.
  task automatic run_read_burst(input logic [2:0] g);
    check("arb_grant", 32'(grant), 32'(0));
    for (int k = 0; k < 16; k++) begin
      step();
      check("rd_grant",    32'(grant),            32'(g));
      check("rd_grant_wr", 32'(grant_wr),         32'(0));
      check("rd_beat_cnt", 32'(beat_cnt),         32'(k));
      check("rd_ram_rd",   32'(ram_read_enable),  32'(1));
      check("rd_ram_wr",   32'(ram_write_enable), 32'(0));
      check("rd_put",      32'(put_v),            32'(g));
      check("rd_get",      32'(get_v),            32'(0));
      check("rd_done_low", 32'(burst_done),       32'(0));
    end
    step();
    check("rel_done",     32'(burst_done),      32'(1));
    check("rel_beat_cnt", 32'(beat_cnt),        32'(16));
    check("rel_ram_rd",   32'(ram_read_enable), 32'(0));
    check("rel_put",      32'(put_v),           32'(0));
  endtask

  initial begin
    reset = 1'b0; chipselect = 1'b0;
    fft_rd_req = 1'b0; fir_rd_req = 1'b0; iir_rd_req = 1'b0;
    fft_wr_req = 1'b0; fir_wr_req = 1'b0; iir_wr_req = 1'b0;
    to_fft_full = 1'b0; to_fir_full = 1'b0; to_iir_full = 1'b0;
    from_fft_empty = 1'b1; from_fir_empty = 1'b1; from_iir_empty = 1'b1;

    // Reset state
    step();
    check("rst_grant",    32'(grant),      32'(0));
    check("rst_beat_cnt", 32'(beat_cnt),   32'(0));
    check("rst_done",     32'(burst_done), 32'(0));
    step();
    reset = 1'b1;

    // Single FFT read requester: ARB, 16 beats, RELEASE, then re-grant
    chipselect = 1'b1; fft_rd_req = 1'b1;
    #1;
    check("idle_grant", 32'(grant),           32'(0));
    check("idle_ram_rd", 32'(ram_read_enable), 32'(0));
    step();
    run_read_burst(3'b001);
    step();
    check("s1_arb_grant", 32'(grant),      32'(0));
    check("s1_arb_done",  32'(burst_done), 32'(0));
    step();
    check("s1_regrant",     32'(grant),           32'(3'b001));
    check("s1_regrant_rd",  32'(ram_read_enable), 32'(1));
    check("s1_regrant_cnt", 32'(beat_cnt),        32'(0));
    fft_rd_req = 1'b0;
    #1;
    check("s1_drop_rd",  32'(ram_read_enable), 32'(0));
    check("s1_drop_put", 32'(fft_put_req),     32'(0));
    step();
    check("s1_drop_done", 32'(burst_done), 32'(1));
    check("s1_drop_cnt",  32'(beat_cnt),   32'(0));
    step();
    check("s1_idle_grant", 32'(grant),      32'(0));
    check("s1_idle_done",  32'(burst_done), 32'(0));

    // FIR write burst: 3 beats, then FIFO empty for 4 cycles -> timeout
    fir_wr_req = 1'b1; from_fir_empty = 1'b0;
    step();
    check("st_arb_grant", 32'(grant), 32'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      check("st_grant",    32'(grant),            32'(3'b010));
      check("st_grant_wr", 32'(grant_wr),         32'(1));
      check("st_ram_wr",   32'(ram_write_enable), 32'(1));
      check("st_ram_rd",   32'(ram_read_enable),  32'(0));
      check("st_get",      32'(get_v),            32'(3'b010));
      check("st_cnt",      32'(beat_cnt),         32'(k));
    end
    step();
    from_fir_empty = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) step();
      check("st_stall_wr",   32'(ram_write_enable), 32'(0));
      check("st_stall_get",  32'(fir_get_req),      32'(0));
      check("st_stall_cnt",  32'(beat_cnt),         32'(3));
      check("st_stall_done", 32'(burst_done),       32'(0));
      check("st_stall_gnt",  32'(grant),            32'(3'b010));
    end
    step();
    check("st_rel_done", 32'(burst_done),       32'(1));
    check("st_rel_cnt",  32'(beat_cnt),         32'(3));
    check("st_rel_wr",   32'(ram_write_enable), 32'(0));
    fir_wr_req = 1'b0;
    step();
    check("st_idle_grant", 32'(grant), 32'(0));

    // IIR requests both directions: write wins, read strobes never fire
    iir_rd_req = 1'b1; iir_wr_req = 1'b1; from_iir_empty = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("dp_grant",    32'(grant),            32'(3'b100));
      check("dp_grant_wr", 32'(grant_wr),         32'(1));
      check("dp_get",      32'(iir_get_req),      32'(1));
      check("dp_put",      32'(iir_put_req),      32'(0));
      check("dp_ram_rd",   32'(ram_read_enable),  32'(0));
      check("dp_ram_wr",   32'(ram_write_enable), 32'(1));
    end
    step();
    iir_wr_req = 1'b0;
    #1;
    check("dp_drop_wr",  32'(ram_write_enable), 32'(0));
    check("dp_drop_rd",  32'(ram_read_enable),  32'(0));
    check("dp_drop_put", 32'(iir_put_req),      32'(0));
    step();
    check("dp_rel_done", 32'(burst_done), 32'(1));
    check("dp_rel_cnt",  32'(beat_cnt),   32'(3));
    iir_rd_req = 1'b0;
    step();
    check("dp_idle_grant", 32'(grant), 32'(0));

    // Round-robin: last served was IIR, so FFT, FIR, IIR, then FFT again
    fft_rd_req = 1'b1; fir_rd_req = 1'b1; iir_rd_req = 1'b1;
    step();
    run_read_burst(3'b001);
    step();
    run_read_burst(3'b010);
    step();
    run_read_burst(3'b100);
    step();
    check("rr_arb4", 32'(grant), 32'(0));

    // Abort: chipselect drops at beat 5 of the fourth (FFT) burst
    for (int k = 0; k < 5; k++) begin
      step();
      check("ab_grant", 32'(grant),    32'(3'b001));
      check("ab_cnt",   32'(beat_cnt), 32'(k));
    end
    step();
    check("ab_cnt5", 32'(beat_cnt), 32'(5));
    chipselect = 1'b0;
    #1;
    check("ab_ram_rd", 32'(ram_read_enable), 32'(0));
    check("ab_put",    32'(put_v),           32'(0));
    check("ab_grant0", 32'(grant),           32'(0));
    check("ab_done",   32'(burst_done),      32'(0));
    step();
    check("ab_idle_grant", 32'(grant),      32'(0));
    check("ab_idle_done",  32'(burst_done), 32'(0));
    check("ab_idle_cnt",   32'(beat_cnt),   32'(0));
    step();
    check("ab_idle2_done", 32'(burst_done),      32'(0));
    check("ab_idle2_rd",   32'(ram_read_enable), 32'(0));

    // Async reset mid-XFER, then only FFT requests after release
    chipselect = 1'b1;
    step();
    step();
    check("ar_grant", 32'(grant), 32'(3'b001));
    step();
    step();
    check("ar_cnt2", 32'(beat_cnt), 32'(2));
    #1;
    reset = 1'b0;
    #1;
    check("ar_grant0", 32'(grant),            32'(0));
    check("ar_rd0",    32'(ram_read_enable),  32'(0));
    check("ar_put0",   32'(put_v),            32'(0));
    check("ar_cnt0",   32'(beat_cnt),         32'(0));
    check("ar_done0",  32'(burst_done),       32'(0));
    check("ar_wr0",    32'(grant_wr),         32'(0));
    fir_rd_req = 1'b0; iir_rd_req = 1'b0;
    step();
    check("ar_hold_grant", 32'(grant), 32'(0));
    reset = 1'b1;
    step();
    check("ar_arb_grant", 32'(grant),      32'(0));
    check("ar_arb_done",  32'(burst_done), 32'(0));
    step();
    check("ar_first_grant", 32'(grant),           32'(3'b001));
    check("ar_first_rd",    32'(ram_read_enable), 32'(1));
    check("ar_first_cnt",   32'(beat_cnt),        32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM port (ram_read_enable / ram_write_enable) among the FFT, FIR and IIR accelerators.
- Each accelerator requests read bursts (RAM -> to_X FIFO) or write bursts (from_X FIFO -> RAM). The arbiter grants one requester at a time, round-robin.
- It drives the per-accelerator FIFO put/get strobes and counts beats, ending each burst on length, request drop or stall timeout.
- Sits between the data bus controller and the address calculator; grant and beat_cnt feed address generation.

Parameters:
BURST_LEN, 16, maximum beats per grant
CNT_W, 5, width of beat counter (must hold BURST_LEN)
STALL_MAX, 4, consecutive stalled cycles that terminate a grant

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
chipselect  in  1  global enable; low forces IDLE
fft_rd_req, fir_rd_req, iir_rd_req  in  1  requester wants RAM->FIFO burst
fft_wr_req, fir_wr_req, iir_wr_req  in  1  requester wants FIFO->RAM burst
to_fft_full, to_fir_full, to_iir_full  in  1  input FIFO full (blocks read beats)
from_fft_empty, from_fir_empty, from_iir_empty  in  1  output FIFO empty (blocks write beats)
grant  out  3  one-hot {iir,fir,fft}; 0 when no grant
grant_wr  out  1  1 = current grant is write burst
ram_read_enable, ram_write_enable  out  1  RAM port strobes
fft_put_req, fir_put_req, iir_put_req  out  1  push RAM data into to_X FIFO
fft_get_req, fir_get_req, iir_get_req  out  1  pop from_X FIFO onto RAM
beat_cnt  out  CNT_W  beats completed in current grant
burst_done  out  1  one-cycle pulse at grant end

Behaviour:
- Reset (reset=0, async): state=IDLE; rr_ptr=fft; all outputs 0.
- States: IDLE, ARB, XFER, RELEASE.
- IDLE -> ARB when chipselect=1 and any *_req=1.
- ARB (1 cycle): pick a requester round-robin, starting after rr_ptr (order fft->fir->iir->fft). Register grant, grant_wr, beat_cnt=0, stall_cnt=0. Go to XFER. If all requests dropped, return to IDLE.
- Direction: if the granted requester has both rd and wr requests, write wins (grant_wr=1).
- XFER beat rules (combinational from registered grant):
  - Read grant, to_X_full=0 and rd_req=1: ram_read_enable=1 and X_put_req=1 in the same cycle (RAM read is zero-latency to the bus).
  - Write grant, from_X_empty=0 and wr_req=1: ram_write_enable=1 and X_get_req=1.
  - Otherwise the cycle is a stall. All strobes of non-granted accelerators are 0; read and write strobes are never high together.
- Beat: beat_cnt++, stall_cnt=0. Stall: stall_cnt++ (saturating).
- XFER -> RELEASE when any of:
  - a beat occurs with beat_cnt==BURST_LEN-1;
  - the granted direction's req is 0;
  - stall_cnt reaches STALL_MAX.
- RELEASE (1 cycle): all strobes 0, burst_done=1, beat_cnt holds the final count, rr_ptr=granted requester. Then -> ARB if any request is pending, else IDLE. Dead cycle guarantees bus turnaround.
- chipselect=0 in any state: next cycle IDLE, grant=0, strobes 0 (combinationally gated immediately); no burst_done pulse.
- Reset mid-burst: immediate clear; partial beats are not reported.
- FIFO full/empty toggling mid-burst only stalls; it does not reset beat_cnt.

Decomposition:
- Shared package: state encoding (IDLE/ARB/XFER/RELEASE), requester index constants (FFT=0, FIR=1, IIR=2), one-hot grant constants.
- Sub-module rr_picker_3: combinational 3-way round-robin priority selector (inputs request vector and rr_ptr; output one-hot grant).

Test Plan:
- Single requester: fft_rd_req=1, to_fft_full=0 for 20 cycles -> grant=001 from cycle 2; 16 cycles of ram_read_enable=fft_put_req=1; burst_done at beat 16; new grant to fft after the dead cycle.
- Round-robin: all three rd_req held, FIFOs never full -> grants fft, fir, iir, fft, each 16 beats, with a RELEASE cycle between them.
- Stall timeout: fir_wr_req=1, from_fir_empty=0 for 3 beats then 1 -> beat_cnt=3; release after 4 stall cycles; burst_done=1; ram_write_enable low during stalls.
- Direction priority: iir_rd_req=iir_wr_req=1 -> grant_wr=1; iir_get_req strobes only; iir_put_req never 1.
- Abort: chipselect dropped at beat 5 of an fft burst -> strobes 0 the same cycle; IDLE next cycle; no burst_done.
- Async reset asserted mid-XFER (between clock edges) -> all outputs 0 immediately; after release, first grant goes to fft.
